// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if
//   Bundles the serial input side and the parallel result side of the
//   UART receive deframer.
//   master : the deframer (consumes baud_tick/rx_in, drives results)
//   slave  : the surrounding logic (drives baud_tick/rx_in, consumes results)
//   Signals:
//     baud_tick      one-clk enable, OVERSAMPLE pulses per bit time
//     rx_in          asynchronous serial line, idle high
//     data_out       last received data word
//     parity_out     last received parity bit
//     rx_valid       one-clk pulse when a new frame is presented
//     framing_error  stop bit of the last frame was sampled low
//     rx_busy        receiver is inside a frame
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_out;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 rx_busy;

  modport master (
    input  baud_tick, rx_in,
    output data_out, parity_out, rx_valid, framing_error, rx_busy
  );

  modport slave (
    output baud_tick, rx_in,
    input  data_out, parity_out, rx_valid, framing_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   UART receive front end. Synchronises rx_in, qualifies the start bit at
//   its centre, shifts DATA_BITS data bits in LSB first, captures the parity
//   bit and samples the stop bit. The frame is presented on data_out /
//   parity_out with a one-clk rx_valid pulse; parity is checked downstream.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    uart_rx_deframer_if.master (baud_tick, rx_in in; results out)
module uart_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_deframer_if.master   bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] NBITS     = BW'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d, tick_nx;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d, bit_nx;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 armed_q, armed_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 parity_out_q, parity_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 rx_busy_q, rx_busy_d;

  // Next-state logic: synchroniser, frame FSM, counters and output captures.
  always_comb begin
    rx_meta_d       = bus.rx_in;
    rx_s_d          = rx_meta_q;
    state_d         = state_q;
    tick_nx         = tick_cnt_q;
    bit_nx          = bit_cnt_q;
    shreg_d         = shreg_q;
    par_d           = par_q;
    armed_d         = armed_q;
    data_out_d      = data_out_q;
    parity_out_d    = parity_out_q;
    framing_error_d = framing_error_q;
    rx_valid_d      = 1'b0;

    if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          // armed stays low after a framing error until the line is seen
          // idle, so a stuck-low line cannot retrigger frames.
          if (armed_q && !rx_s_q) begin
            state_d = START;
          end else if (rx_s_q) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
        end
        START: begin
          if (tick_cnt_q == MID_TICK) begin
            // A high level at the start-bit centre is a glitch: drop back quietly.
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tick_nx = tick_cnt_q + TW'(1'b1);
          end
        end
        DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_nx  = bit_cnt_q + BW'(1'b1);
            tick_nx = {TW{1'b0}};
            if (bit_nx == NBITS) begin
              state_d = PARITY;
            end else begin
              state_d = DATA;
            end
          end else begin
            tick_nx = tick_cnt_q + TW'(1'b1);
          end
        end
        PARITY: begin
          if (tick_cnt_q == LAST_TICK) begin
            par_d   = rx_s_q;
            state_d = STOP;
          end else begin
            tick_nx = tick_cnt_q + TW'(1'b1);
          end
        end
        STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            // Deliver even on a bad stop bit; framing_error flags it.
            data_out_d      = shreg_q;
            parity_out_d    = par_q;
            framing_error_d = ~rx_s_q;
            rx_valid_d      = 1'b1;
            armed_d         = rx_s_q;
            state_d         = IDLE;
          end else begin
            tick_nx = tick_cnt_q + TW'(1'b1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Counters restart from zero whenever the state changes.
    tick_cnt_d = (state_d != state_q) ? {TW{1'b0}} : tick_nx;
    bit_cnt_d  = (state_d != state_q) ? {BW{1'b0}} : bit_nx;
    rx_busy_d  = (state_d != IDLE);
  end

  // State and output registers; the synchroniser resets to the idle-line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tick_cnt_q      <= {TW{1'b0}};
      bit_cnt_q       <= {BW{1'b0}};
      shreg_q         <= {DATA_BITS{1'b0}};
      par_q           <= 1'b0;
      armed_q         <= 1'b1;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      data_out_q      <= {DATA_BITS{1'b0}};
      parity_out_q    <= 1'b0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      par_q           <= par_d;
      armed_q         <= armed_d;
      rx_meta_q       <= rx_meta_d;
      rx_s_q          <= rx_s_d;
      data_out_q      <= data_out_d;
      parity_out_q    <= parity_out_d;
      rx_valid_q      <= rx_valid_d;
      framing_error_q <= framing_error_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.parity_out    = parity_out_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.rx_busy       = rx_busy_q;

endmodule
